// File: rtl/pq_pkg.sv
// Shared types and sizing for the shift-register priority queue.
package pq_pkg;

  localparam int KEY_WIDTH   = 8;
  localparam int VAL_WIDTH   = 8;
  localparam int PQ_CAPACITY = 8;

  typedef struct packed {
    logic [KEY_WIDTH-1:0] key;
    logic [VAL_WIDTH-1:0] value;
  } kv_t;

  localparam logic [KEY_WIDTH-1:0] KEYINF   = '1;
  localparam kv_t                  KV_EMPTY = '{key: KEYINF, value: '0};

endpackage

// File: rtl/pq_if.sv
// Bundle between the priority queue and its environment.
import pq_pkg::*;

interface pq_if (input logic clk);
  logic rst;
  logic enq;
  logic deq;
  kv_t  kvi;
  kv_t  kvo;
  logic busy;
  logic full;
  logic empty;

  modport dev (input clk, rst, enq, deq, kvi, output kvo, busy, full, empty);
  modport tb  (input clk, kvo, busy, full, empty, output rst, enq, deq, kvi);
endinterface

// File: rtl/sr_pq_s_cell.sv
// One slot of the sorted shift register: holds {valid, kv} and decides each
// cycle whether to hold, take kvi, or take a neighbour's entry.
module sr_pq_s_cell
  import pq_pkg::*;
#(
  parameter bit BOTTOM = 1'b0   // cell 0: no real neighbour below
) (
  input  logic clk,
  input  logic rst,
  input  logic ins,             // qualified insert (also set during replace)
  input  logic rem,             // qualified remove (also set during replace)
  input  kv_t  kvi,
  input  logic below_valid,
  input  logic below_keep,
  input  kv_t  below_kv,
  input  logic above_valid,
  input  logic above_keep,
  input  kv_t  above_kv,
  output logic valid,
  output logic keep,
  output kv_t  kv
);

  logic nxt_valid;
  kv_t  nxt_kv;

  // An entry stays below kvi when its key is <= kvi.key, so equal keys keep FIFO order.
  assign keep = valid && (kv.key <= kvi.key);

  // Next-entry selection for insert, remove and replace.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    nxt_valid = valid;
    nxt_kv    = kv;
    if (ins && rem) begin
      // Replace: view the array after a shift-down, then insert into it.
      // The post-remove occupant of this slot is the cell above, and the one
      // below it is this cell's current entry; the head itself is discarded.
      if (above_keep) begin
        nxt_valid = 1'b1;
        nxt_kv    = above_kv;
      end else if (keep || BOTTOM) begin
        nxt_valid = 1'b1;
        nxt_kv    = kvi;
      end
    end else if (rem) begin
      nxt_valid = above_valid;
      nxt_kv    = above_kv;
    end else if (ins) begin
      if (keep) begin
        nxt_valid = valid;
      end else if (below_keep || BOTTOM) begin
        nxt_valid = 1'b1;
        nxt_kv    = kvi;
      end else if (below_valid) begin
        nxt_valid = 1'b1;
        nxt_kv    = below_kv;
      end
    end
  end

  // Slot register with synchronous reset to an empty slot.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all cells shift off the same old values.
    if (rst) begin
      valid <= 1'b0;
      kv    <= KV_EMPTY;
    end else begin
      valid <= nxt_valid;
      kv    <= nxt_kv;
    end
  end

endmodule

// File: rtl/sr_pq_s.sv
// Single-cycle shift-register min-priority queue of key/value pairs.
module sr_pq_s
  import pq_pkg::*;
(
  pq_if.dev pq
);

  // Index i+1 is cell i; indices 0 and PQ_CAPACITY+1 are the tied-off ends.
  logic [PQ_CAPACITY+1:0] v_ext;
  logic [PQ_CAPACITY+1:0] k_ext;
  kv_t                    kv_ext [PQ_CAPACITY+2];
  logic                   ins;
  logic                   rem;

  assign v_ext[0]               = 1'b0;
  assign k_ext[0]               = 1'b0;
  assign kv_ext[0]              = KV_EMPTY;
  assign v_ext[PQ_CAPACITY+1]   = 1'b0;
  assign k_ext[PQ_CAPACITY+1]   = 1'b0;
  assign kv_ext[PQ_CAPACITY+1]  = KV_EMPTY;

  // Status comes straight from the registered valid run.
  assign pq.empty = ~v_ext[1];
  assign pq.full  = v_ext[PQ_CAPACITY];
  assign pq.busy  = 1'b0;
  assign pq.kvo   = v_ext[1] ? kv_ext[1] : KV_EMPTY;

  // Enq on a full queue is only honoured as part of a replace; enq+deq on an
  // empty queue degenerates to a plain insert because rem stays low.
  assign ins = pq.enq & (pq.deq | ~pq.full);
  assign rem = pq.deq & ~pq.empty;

  for (genvar i = 0; i < PQ_CAPACITY; i++) begin : g_cell
    sr_pq_s_cell #(
      .BOTTOM ((i == 0) ? 1'b1 : 1'b0)
    ) u_cell (
      .clk         (pq.clk),
      .rst         (pq.rst),
      .ins         (ins),
      .rem         (rem),
      .kvi         (pq.kvi),
      .below_valid (v_ext[i]),
      .below_keep  (k_ext[i]),
      .below_kv    (kv_ext[i]),
      .above_valid (v_ext[i+2]),
      .above_keep  (k_ext[i+2]),
      .above_kv    (kv_ext[i+2]),
      .valid       (v_ext[i+1]),
      .keep        (k_ext[i+1]),
      .kv          (kv_ext[i+1])
    );
  end

endmodule

// File: tb/tb_sr_pq_s.sv
// Self-checking bench for sr_pq_s: vector table, directed corners and a
// random run against a stable sorted-queue model.
module tb_sr_pq_s;
  import pq_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  pq_if bus (.clk(clk));
  sr_pq_s dut (.pq(bus));

  int  n_tests = 0;
  int  n_fail  = 0;
  kv_t model [$];
  kv_t sb    [$];

  typedef struct {
    logic enq;
    logic deq;
    kv_t  kvi;
    kv_t  exp_kvo;
    logic exp_full;
    logic exp_empty;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic kv_t mk(input int k, input int v);
    kv_t r;
    r.key   = k[KEY_WIDTH-1:0];
    r.value = v[VAL_WIDTH-1:0];
    return r;
  endfunction

  function automatic kv_t model_head();
    return (model.size() > 0) ? model[0] : KV_EMPTY;
  endfunction

  // Drive one cycle, update the model, check the dequeued value before the
  // edge and the visible state after it.
  task automatic step(input logic r, input logic e, input logic d, input kv_t k);
    bit  removed;
    int  pos;
    kv_t got;
    removed = 0;
    @(negedge clk);
    bus.rst = r;
    bus.enq = e;
    bus.deq = d;
    bus.kvi = k;
    #1;
    if (r) begin
      model.delete();
    end else begin
      if (d && model.size() > 0) begin
        sb.push_back(model[0]);
        void'(model.pop_front());
        removed = 1;
      end
      if (e && (removed || model.size() < PQ_CAPACITY)) begin
        pos = model.size();
        for (int i = 0; i < model.size(); i++) begin
          if (model[i].key > k.key) begin
            pos = i;
            break;
          end
        end
        model.insert(pos, k);
      end
    end
    if (sb.size() > 0) begin
      got = sb.pop_front();
      check("deq_value", bus.kvo, got);
    end
    @(posedge clk);
    #1;
    check("model_kvo",   bus.kvo,   model_head());
    check("model_full",  bus.full,  model.size() == PQ_CAPACITY);
    check("model_empty", bus.empty, model.size() == 0);
    check("model_busy",  bus.busy,  1'b0);
  endtask

  vec_t vecs [10];

  initial begin
    bus.rst = 1'b1;
    bus.enq = 1'b0;
    bus.deq = 1'b0;
    bus.kvi = KV_EMPTY;

    // Reset then idle.
    step(1'b1, 1'b0, 1'b0, KV_EMPTY);
    step(1'b0, 1'b0, 1'b0, KV_EMPTY);
    step(1'b0, 1'b0, 1'b0, KV_EMPTY);
    check("rst_empty", bus.empty, 1'b1);
    check("rst_full",  bus.full,  1'b0);
    check("rst_busy",  bus.busy,  1'b0);
    check("rst_kvo",   bus.kvo,   KV_EMPTY);

    // Insert with a tie, then drain; tie leaves in arrival order.
    vecs[0] = '{1'b1, 1'b0, mk(5, 8'h15), mk(5, 8'h15), 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, mk(2, 8'h12), mk(2, 8'h12), 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, mk(7, 8'h17), mk(2, 8'h12), 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, mk(2, 8'h09), mk(2, 8'h12), 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, mk(0, 8'h10), mk(0, 8'h10), 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, KV_EMPTY,     mk(2, 8'h12), 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, KV_EMPTY,     mk(2, 8'h09), 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b1, KV_EMPTY,     mk(5, 8'h15), 1'b0, 1'b0};
    vecs[8] = '{1'b0, 1'b1, KV_EMPTY,     mk(7, 8'h17), 1'b0, 1'b0};
    vecs[9] = '{1'b0, 1'b1, KV_EMPTY,     KV_EMPTY,     1'b0, 1'b1};
    for (int i = 0; i < 10; i++) begin
      step(1'b0, vecs[i].enq, vecs[i].deq, vecs[i].kvi);
      check($sformatf("vec%0d_kvo", i),   bus.kvo,   vecs[i].exp_kvo);
      check($sformatf("vec%0d_full", i),  bus.full,  vecs[i].exp_full);
      check($sformatf("vec%0d_empty", i), bus.empty, vecs[i].exp_empty);
    end

    // Fill, overfill, replace while full.
    for (int i = 0; i < PQ_CAPACITY; i++) step(1'b0, 1'b1, 1'b0, mk(80 - 10 * i, i));
    check("fill_full", bus.full, 1'b1);
    check("fill_head", bus.kvo.key, 8'd10);
    step(1'b0, 1'b1, 1'b0, mk(1, 8'hAA));
    check("overfill_head", bus.kvo.key, 8'd10);
    check("overfill_full", bus.full, 1'b1);
    step(1'b0, 1'b1, 1'b1, mk(1, 8'hAB));
    check("replace_head", bus.kvo, mk(1, 8'hAB));
    check("replace_full", bus.full, 1'b1);
    step(1'b0, 1'b0, 1'b1, KV_EMPTY);
    check("after_replace_head", bus.kvo.key, 8'd20);

    // Empty-queue requests.
    step(1'b1, 1'b0, 1'b0, KV_EMPTY);
    step(1'b0, 1'b0, 1'b1, KV_EMPTY);
    check("deq_empty_empty", bus.empty, 1'b1);
    check("deq_empty_kvo",   bus.kvo,   KV_EMPTY);
    step(1'b0, 1'b1, 1'b1, mk(4, 8'h44));
    check("encdeq_empty_kvo",   bus.kvo.key, 8'd4);
    check("encdeq_empty_empty", bus.empty,   1'b0);

    // Key KEYINF is a real entry.
    step(1'b0, 1'b0, 1'b1, KV_EMPTY);
    step(1'b0, 1'b1, 1'b0, mk(255, 8'h01));
    check("keyinf_empty", bus.empty, 1'b0);
    check("keyinf_kvo",   bus.kvo,   mk(255, 8'h01));

    // Reset wins over a simultaneous enq.
    step(1'b1, 1'b0, 1'b0, KV_EMPTY);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, mk(3 + i, i));
    step(1'b1, 1'b1, 1'b0, mk(0, 8'h55));
    check("midrst_empty", bus.empty, 1'b1);
    check("midrst_kvo",   bus.kvo,   KV_EMPTY);

    // Random enq/deq/replace with narrow keys to provoke ties.
    for (int c = 0; c < 10000; c++) begin
      logic e, d, r;
      r = ($urandom_range(0, 999) == 0);
      e = ($urandom_range(0, 99) < 55);
      d = ($urandom_range(0, 99) < 45);
      step(r, e, d, mk($urandom_range(0, 15), $urandom_range(0, 255)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
